// File: rtl/preedge_sync_fifo.sv
// Fast-to-slow crossing FIFO clocked on the fast clock; slow-side view updates only on PREEDGE edges.
// Optional sticky ERR output enabled by defining PREEDGE_SYNC_FIFO_ERR_EN.
module preedge_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ENQ,
  input  logic [WIDTH-1:0] D_IN,
  output logic             FULL_N,
  input  logic             PREEDGE,
  input  logic             DEQ,
  output logic [WIDTH-1:0] D_OUT,
  output logic             EMPTY_N
`ifdef PREEDGE_SYNC_FIFO_ERR_EN
  ,
  output logic             ERR
`endif
);

  localparam logic [AW:0] L_DEPTH = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic [WIDTH-1:0] r_d_out;
  logic             r_empty_n;

  logic             w_full_n;
  logic             w_enq;
  logic             w_pop;
  logic [AW-1:0]    w_rptr_next;
  logic [AW:0]      w_count_popped;

  // Handshake: an enqueue happens when ENQ=1 and FULL_N=1 on the same edge; a dequeue
  // happens when DEQ=1 and EMPTY_N=1 on an edge with PREEDGE=1. Other requests are dropped.
  assign w_full_n       = (r_count != L_DEPTH);
  assign w_enq          = ENQ & w_full_n;
  assign w_pop          = PREEDGE & DEQ & r_empty_n;
  assign w_rptr_next    = r_rptr + AW'(w_pop);
  assign w_count_popped = r_count - (AW+1)'(w_pop);

  assign FULL_N  = w_full_n;
  assign D_OUT   = r_d_out;
  assign EMPTY_N = r_empty_n;

  always_ff @(posedge CLK) begin
    if (w_enq) begin
      r_mem[r_wptr] <= D_IN;
    end
  end

  // The slow view uses pre-enqueue state, so a same-edge write shows up one PREEDGE later.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_d_out   <= '0;
      r_empty_n <= 1'b0;
    end else begin
      if (w_enq) begin
        r_wptr <= r_wptr + AW'(1);
      end
      r_rptr  <= w_rptr_next;
      r_count <= r_count + (AW+1)'(w_enq) - (AW+1)'(w_pop);
      if (PREEDGE) begin
        r_empty_n <= (w_count_popped != '0);
        if (w_count_popped != '0) begin
          r_d_out <= r_mem[w_rptr_next];
        end
      end
    end
  end

`ifdef PREEDGE_SYNC_FIFO_ERR_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      ERR <= 1'b0;
    end else if ((ENQ & ~w_full_n) | (PREEDGE & DEQ & ~r_empty_n)) begin
      ERR <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_preedge_sync_fifo.sv
// Self-checking bench for preedge_sync_fifo: directed scenarios plus randomized traffic
// checked against a queue-based model of the slow-side view.
module tb_preedge_sync_fifo;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic             CLK = 1'b0;
  logic             RST = 1'b0;
  logic             ENQ = 1'b0;
  logic [WIDTH-1:0] D_IN = '0;
  logic             FULL_N;
  logic             PREEDGE = 1'b0;
  logic             DEQ = 1'b0;
  logic [WIDTH-1:0] D_OUT;
  logic             EMPTY_N;
`ifdef PREEDGE_SYNC_FIFO_ERR_EN
  logic             ERR;
`endif

  preedge_sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
    .CLK(CLK),
    .RST(RST),
    .ENQ(ENQ),
    .D_IN(D_IN),
    .FULL_N(FULL_N),
    .PREEDGE(PREEDGE),
    .DEQ(DEQ),
    .D_OUT(D_OUT),
    .EMPTY_N(EMPTY_N)
`ifdef PREEDGE_SYNC_FIFO_ERR_EN
    ,
    .ERR(ERR)
`endif
  );

  // Clock / reset block
  always #5 CLK = ~CLK;

  int vectors     = 0;
  int miscompares = 0;

  // Scoreboard: every accepted entry in order, plus the slow-side view it should present.
  logic [WIDTH-1:0] exp_q[$];
  logic             m_empty_n = 1'b0;
  logic [WIDTH-1:0] m_dout    = '0;
  logic             m_err     = 1'b0;

  // Driver: apply one cycle of inputs, advance the model at the edge, return at the negedge.
  task automatic step(input logic rst, input logic enq, input logic [WIDTH-1:0] din,
                      input logic pre, input logic deq);
    logic full;
    RST = rst; ENQ = enq; D_IN = din; PREEDGE = pre; DEQ = deq;
    @(posedge CLK);
    full = (exp_q.size() >= DEPTH);
    if (rst) begin
      exp_q.delete();
      m_empty_n = 1'b0;
      m_dout    = '0;
      m_err     = 1'b0;
    end else begin
      if ((enq && full) || (pre && deq && !m_empty_n)) m_err = 1'b1;
      if (pre) begin
        if (deq && m_empty_n) void'(exp_q.pop_front());
        if (exp_q.size() != 0) begin
          m_empty_n = 1'b1;
          m_dout    = exp_q[0];
        end else begin
          m_empty_n = 1'b0;
        end
      end
      if (enq && !full) exp_q.push_back(din);
    end
    @(negedge CLK);
  endtask

  task automatic test_reset();
    for (int c = 0; c < 8; c++) begin
      step(c < 2, 1'b0, '0, (c % 3) == 2, 1'b0);
      vectors++;
      if ({FULL_N, EMPTY_N, D_OUT} !== {1'b1, 1'b0, 8'h00}) begin
        miscompares++;
        $display("FAIL reset_idle c=%0d got full_n=%b empty_n=%b dout=%h want 1 0 00",
                 c, FULL_N, EMPTY_N, D_OUT);
      end
    end
  endtask

  task automatic test_single_transfer();
    logic [WIDTH+1:0] want [3];
    want[0] = {1'b1, 1'b0, 8'h00};
    want[1] = {1'b1, 1'b0, 8'h00};
    want[2] = {1'b1, 1'b1, 8'hA5};
    for (int c = 0; c < 3; c++) begin
      step(1'b0, c == 0, 8'hA5, c == 2, 1'b0);
      vectors++;
      if ({FULL_N, EMPTY_N, D_OUT} !== want[c]) begin
        miscompares++;
        $display("FAIL single_transfer c=%0d got %b_%b_%h want %h", c, FULL_N, EMPTY_N, D_OUT, want[c]);
      end
    end
    step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    vectors++;
    if ({EMPTY_N, D_OUT} !== {1'b0, 8'hA5}) begin
      miscompares++;
      $display("FAIL single_drain got empty_n=%b dout=%h want 0 a5", EMPTY_N, D_OUT);
    end
  endtask

  task automatic test_same_edge();
    step(1'b0, 1'b1, 8'h11, 1'b1, 1'b0);
    vectors++;
    if (EMPTY_N !== 1'b0) begin
      miscompares++;
      $display("FAIL same_edge_hidden got empty_n=%b want 0", EMPTY_N);
    end
    step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    vectors++;
    if ({EMPTY_N, D_OUT} !== {1'b1, 8'h11}) begin
      miscompares++;
      $display("FAIL same_edge_visible got empty_n=%b dout=%h want 1 11", EMPTY_N, D_OUT);
    end
    step(1'b0, 1'b0, '0, 1'b1, 1'b1);
  endtask

  task automatic test_fill_drain();
    for (int pass = 0; pass < 2; pass++) begin
      for (int k = 1; k <= 5; k++) begin
        step(1'b0, 1'b1, 8'((pass * 4) + k), 1'b0, 1'b0);
        vectors++;
        if (FULL_N !== (k < DEPTH)) begin
          miscompares++;
          $display("FAIL fill pass=%0d k=%0d got full_n=%b want %b", pass, k, FULL_N, k < DEPTH);
        end
      end
      for (int e = 1; e <= 5; e++) begin
        step(1'b0, 1'b0, '0, 1'b1, 1'b1);
        vectors++;
        if (e <= 4 && {EMPTY_N, D_OUT} !== {1'b1, 8'((pass * 4) + e)}) begin
          miscompares++;
          $display("FAIL drain pass=%0d e=%0d got empty_n=%b dout=%h want 1 %h",
                   pass, e, EMPTY_N, D_OUT, 8'((pass * 4) + e));
        end else if (e == 5 && {FULL_N, EMPTY_N} !== 2'b10) begin
          miscompares++;
          $display("FAIL drain_end pass=%0d got full_n=%b empty_n=%b want 1 0", pass, FULL_N, EMPTY_N);
        end
      end
    end
  endtask

  task automatic test_deq_illegal();
    step(1'b1, 1'b0, '0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h3C, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    for (int c = 0; c < 3; c++) begin
      step(1'b0, 1'b0, '0, 1'b0, 1'b1);
      vectors++;
      if ({EMPTY_N, D_OUT} !== {1'b1, 8'h3C}) begin
        miscompares++;
        $display("FAIL deq_no_preedge c=%0d got empty_n=%b dout=%h want 1 3c", c, EMPTY_N, D_OUT);
      end
    end
    step(1'b0, 1'b0, '0, 1'b1, 1'b1);
`ifdef PREEDGE_SYNC_FIFO_ERR_EN
    vectors++;
    if (ERR !== 1'b0) begin
      miscompares++;
      $display("FAIL err_clean got %b want 0", ERR);
    end
`endif
    step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    vectors++;
    if ({FULL_N, EMPTY_N} !== 2'b10) begin
      miscompares++;
      $display("FAIL deq_empty got full_n=%b empty_n=%b want 1 0", FULL_N, EMPTY_N);
    end
`ifdef PREEDGE_SYNC_FIFO_ERR_EN
    vectors++;
    if (ERR !== 1'b1) begin
      miscompares++;
      $display("FAIL err_set got %b want 1", ERR);
    end
`endif
    // Four accepted enqueues must fill it exactly, proving the empty DEQ left the count alone.
    for (int k = 0; k < DEPTH; k++) step(1'b0, 1'b1, 8'(k), 1'b0, 1'b0);
    vectors++;
    if (FULL_N !== 1'b0) begin
      miscompares++;
      $display("FAIL count_after_empty_deq got full_n=%b want 0", FULL_N);
    end
  endtask

  task automatic test_mid_reset();
    step(1'b1, 1'b0, '0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 8'h40 + 8'(k), 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 8'hEE, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'h77, 1'b1, 1'b1);
    vectors++;
    if ({FULL_N, EMPTY_N, D_OUT} !== {1'b1, 1'b0, 8'h00}) begin
      miscompares++;
      $display("FAIL mid_reset got full_n=%b empty_n=%b dout=%h want 1 0 00", FULL_N, EMPTY_N, D_OUT);
    end
`ifdef PREEDGE_SYNC_FIFO_ERR_EN
    vectors++;
    if (ERR !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset_err got %b want 0", ERR);
    end
`endif
    for (int k = 0; k < DEPTH; k++) step(1'b0, 1'b1, 8'h50 + 8'(k), 1'b0, 1'b0);
    vectors++;
    if (FULL_N !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset_count got full_n=%b want 0", FULL_N);
    end
  endtask

  task automatic test_random();
    int div;
    int phase;
    div   = 1;
    phase = 0;
    for (int c = 0; c < 1500; c++) begin
      if ((c % 100) == 0) begin
        div   = $urandom_range(1, 4);
        phase = 0;
      end
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 6), 8'($urandom),
           (phase == div - 1), ($urandom_range(0, 9) < 5));
      phase = (phase + 1) % div;
      vectors++;
      if (FULL_N !== (exp_q.size() < DEPTH) || EMPTY_N !== m_empty_n || D_OUT !== m_dout) begin
        miscompares++;
        $display("FAIL random c=%0d got full_n=%b empty_n=%b dout=%h want %b %b %h",
                 c, FULL_N, EMPTY_N, D_OUT, exp_q.size() < DEPTH, m_empty_n, m_dout);
      end
`ifdef PREEDGE_SYNC_FIFO_ERR_EN
      vectors++;
      if (ERR !== m_err) begin
        miscompares++;
        $display("FAIL random_err c=%0d got %b want %b", c, ERR, m_err);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_single_transfer();
    test_same_edge();
    test_fill_drain();
    test_deq_illegal();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
